// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell processes one bit pair per
// cycle, LSB first. The parallel Sum/Cout are registered on completion.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             busy,
   output logic             done
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic [WIDTH-1:0] s_next;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_sum;
   logic             fa_cout;
   logic             last_bit;

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB; for WIDTH=1 it is the whole sum.
   generate
      if (WIDTH == 1) begin : g_s_one
         assign s_next = fa_sum;
      end else begin : g_s_wide
         assign s_next = {fa_sum, s_sh[WIDTH-1:1]};
      end
   endgenerate

   assign last_bit = (cnt == LAST);
   assign busy     = (state == SHIFT);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic: accept in IDLE, WIDTH shift cycles, one DONE cycle.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand/sum shift registers, carry, bit counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         s_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         Sum   <= '0;
         Cout  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  carry <= Cin;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               s_sh  <= s_next;
               carry <= fa_cout;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               cnt   <= cnt + CNT_W'(1);
               if (last_bit) begin
                  Sum  <= s_next;
                  Cout <= fa_cout;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around one instance of the existing `full_adder` cell. It accepts two parallel operands and a carry-in on a start strobe. Each cycle it feeds one bit pair plus the registered carry through the `full_adder`, LSB first, and assembles the parallel sum and carry-out. It sits directly upstream of the `full_adder` and sequences its inputs. It trades WIDTH cycles of latency for a single 1-bit adder in the datapath.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal range is WIDTH >= 1.

Ports. Clock and reset are fixed: one clock, synchronous active-high reset.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `A`  in  WIDTH  operand A; captured when start is accepted.
- `B`  in  WIDTH  operand B; captured when start is accepted.
- `Cin`  in  1  carry-in; captured when start is accepted.
- `Sum`  out  WIDTH  registered result (A+B+Cin)[WIDTH-1:0].
- `Cout`  out  1  registered carry-out, i.e. bit WIDTH of A+B+Cin.
- `busy`  out  1  high while bits are being processed (SHIFT state).
- `done`  out  1  one-cycle pulse when Sum/Cout are updated.

## Operation
- Internal registers:
  - a_sh and b_sh: WIDTH-bit right-shift registers holding the operands.
  - carry: 1 bit.
  - s_sh: WIDTH-bit accumulating shift register for the sum.
  - cnt: $clog2(WIDTH+1) bits.
  - state: one of IDLE, SHIFT, DONE.
- `full_adder` connections: inputs are a_sh[0], b_sh[0] and carry; outputs are the sum bit and the carry bit.
- IDLE:
  - start=1 → load a_sh=A, b_sh=B, carry=Cin, cnt=0; go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, once per cycle:
  - s_sh <= {fa_sum, s_sh[WIDTH-1:1]}.
  - carry <= fa_cout.
  - a_sh and b_sh shift right by 1, with 0 shifted in.
  - cnt <= cnt+1.
  - On the cycle where cnt == WIDTH-1, also:
    - Sum <= {fa_sum, s_sh[WIDTH-1:1]}
    - Cout <= fa_cout
    - done <= 1
    - go to DONE.
- DONE: done returns to 0; go to IDLE unconditionally. start is ignored in DONE.
- Outputs:
  - busy = (state == SHIFT).
  - Sum and Cout change only on completion and hold the last result until the next completion.
- start during SHIFT or DONE is ignored; there is no queueing. A, B and Cin are don't-care except on the accepting cycle.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow is reported only via Cout; there is no separate overflow flag.
- WIDTH=1: exactly one SHIFT cycle, with the same latency rules.
- Reset:
  - rst=1 at any edge forces state=IDLE, Sum=0, Cout=0, done=0, busy=0, and clears all internal registers.
  - Reset mid-operation aborts the operation: no done is issued, and Sum/Cout read 0.
  - rst takes priority over start on the same edge.

## Timing
- Start accepted at edge E0, with state IDLE and start=1.
- busy is high from E0 until E_WIDTH, i.e. for exactly WIDTH cycles.
- Bit i is processed at edge E(i+1).
- Sum, Cout and done=1 are all registered at E_WIDTH. done is high for exactly one cycle, falling at E(WIDTH+1).
- The state is IDLE after E(WIDTH+1). The earliest next accept is at E(WIDTH+2).
- With start held high continuously, throughput is one result per WIDTH+2 cycles.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle, WIDTH=8: Sum=0x00, Cout=0, busy=0, done=0. start=0 for 20 cycles → no change.
- A=0x5A, B=0x3C, Cin=0 → busy high for exactly 8 cycles, then done pulses once with Sum=0x96, Cout=0. Repeat with A=0xFF, B=0x01, Cin=0 → Sum=0x00, Cout=1.
- A=0xFF, B=0xFF, Cin=1 → Sum=0xFF, Cout=1. Also A=0x00, B=0x00, Cin=1 → Sum=0x01, Cout=0.
- Start A=0x12, B=0x34, then pulse start with A=0xAA, B=0xAA at SHIFT cycle 3 and again during DONE → only one done pulse, with Sum=0x46, Cout=0. No second operation starts.
- Start A=0x80, B=0x80; assert rst for one cycle at SHIFT cycle 4 → busy=0 next cycle, no done, Sum=0x00, Cout=0. A following start with A=0x01, B=0x02 → Sum=0x03.
- start held high with fixed A=0x10, B=0x20 → done pulses every 10 cycles, each with Sum=0x30. Randomised check over 1000 operands at WIDTH=1, 8 and 13 against A+B+Cin.
